// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: turns EX loads/stores into data-bus transactions with byte
// enables, stalls the front of the pipe until the bus completes, and registers the MEM/WB word.
module mem_access_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_instr,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [31:0] ex_pc,
  input  logic        ex_lt,
  input  logic        ex_ltu,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        wb_valid,
  output logic [31:0] wb_instr,
  output logic [31:0] wb_result,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_pc,
  output logic        wb_lt,
  output logic        wb_ltu,
  output logic [1:0]  wb_exc
);

  localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       addr_lo;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        misaligned;
  logic        start;
  logic        timeout;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] rdata_aligned;

  assign opcode   = ex_instr[6:0];
  assign funct3   = ex_instr[14:12];
  assign is_load  = (opcode == 7'b0000011);
  assign is_store = (opcode == 7'b0100011);
  assign is_mem   = is_load || is_store;

  assign misaligned = is_mem &&
                      (((funct3[1:0] == 2'b01) && ex_result[0]) ||
                       ((funct3[1:0] == 2'b10) && (ex_result[1:0] != 2'b00)));

  assign start   = ex_valid && is_mem && !misaligned;
  assign timeout = (wait_cnt == CNT_W'(MAX_WAIT - 1));

  // Stall is gated by rst so that every output reads 0 while reset is held.
  always_comb begin
    mem_stall = 1'b0;
    if (!rst) begin
      if (state == IDLE) mem_stall = start;
      else               mem_stall = !dmem_ready && !timeout;
    end
  end

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = ex_store_data;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be_new    = 4'b0001 << ex_result[1:0];
          wdata_new = {4{ex_store_data[7:0]}};
        end
        2'b01: begin
          be_new    = ex_result[1] ? 4'b1100 : 4'b0011;
          wdata_new = {2{ex_store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Lane alignment only; bytes above the access width are left for WB to mask or extend.
  assign rdata_aligned = dmem_rdata >> {addr_lo, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      addr_lo      <= 2'b00;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
      wb_valid     <= 1'b0;
      wb_instr     <= '0;
      wb_result    <= '0;
      wb_read_data <= '0;
      wb_pc        <= '0;
      wb_lt        <= 1'b0;
      wb_ltu       <= 1'b0;
      wb_exc       <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= WAIT;
            wait_cnt   <= '0;
            addr_lo    <= ex_result[1:0];
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {ex_result[31:2], 2'b00};
            dmem_be    <= be_new;
            dmem_wdata <= wdata_new;
            wb_valid   <= 1'b0;
          end else if (ex_valid) begin
            wb_valid     <= 1'b1;
            wb_instr     <= ex_instr;
            wb_result    <= ex_result;
            wb_read_data <= '0;
            wb_pc        <= ex_pc;
            wb_lt        <= ex_lt;
            wb_ltu       <= ex_ltu;
            wb_exc       <= misaligned ? 2'b01 : 2'b00;
          end else begin
            wb_valid <= 1'b0;
          end
        end
        WAIT: begin
          // ex_* is held stable while stalled, so it still describes this access here.
          if (dmem_ready || timeout) begin
            state        <= IDLE;
            dmem_req     <= 1'b0;
            wb_valid     <= 1'b1;
            wb_instr     <= ex_instr;
            wb_result    <= ex_result;
            wb_pc        <= ex_pc;
            wb_lt        <= ex_lt;
            wb_ltu       <= ex_ltu;
            wb_read_data <= (dmem_ready && !dmem_we) ? rdata_aligned : 32'd0;
            wb_exc       <= dmem_ready ? 2'b00 : 2'b10;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            wb_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: a driver issues ops, a memory responder answers the bus,
// and monitors compare the MEM/WB word and bus fields against a behavioural model.
module tb_mem_access_stage;

  localparam int MAX_WAIT = 16;
  localparam int W = 132;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_instr;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic [31:0] ex_pc;
  logic        ex_lt;
  logic        ex_ltu;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        wb_valid;
  logic [31:0] wb_instr;
  logic [31:0] wb_result;
  logic [31:0] wb_read_data;
  logic [31:0] wb_pc;
  logic        wb_lt;
  logic        wb_ltu;
  logic [1:0]  wb_exc;

  mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .wb_valid(wb_valid), .wb_instr(wb_instr), .wb_result(wb_result),
    .wb_read_data(wb_read_data), .wb_pc(wb_pc), .wb_lt(wb_lt), .wb_ltu(wb_ltu), .wb_exc(wb_exc)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic         bus_active = 1'b0;
  logic [68:0]  bus_exp = '0;
  int           resp_delay = 0;
  bit           resp_never = 1'b0;
  logic [31:0]  resp_rdata = '0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_mem_op(input logic [31:0] instr);
    return (instr[6:0] == 7'h03) || (instr[6:0] == 7'h23);
  endfunction

  function automatic bit is_misaligned(input logic [31:0] instr, input logic [31:0] addr);
    return is_mem_op(instr) && ((addr % size_bytes(instr[14:12])) != 0);
  endfunction

  function automatic logic [W-1:0] model_wb(input logic [31:0] instr, addr, pc,
                                            input logic lt, ltu, input logic [31:0] rdata,
                                            input bit never);
    logic [31:0] rd;
    logic [1:0]  exc;
    bit mem;
    bit mis;
    mem = is_mem_op(instr);
    mis = is_misaligned(instr, addr);
    exc = mis ? 2'd1 : ((mem && never) ? 2'd2 : 2'd0);
    rd  = 32'd0;
    if (instr[6:0] == 7'h03 && !mis && !never) rd = rdata / (32'd1 << (8 * (addr % 4)));
    return {instr, addr, rd, pc, lt, ltu, exc};
  endfunction

  function automatic logic [68:0] model_bus(input logic [31:0] instr, addr, sd);
    logic [31:0] wd;
    logic [3:0]  be;
    int nb;
    int lane;
    bit st;
    st = (instr[6:0] == 7'h23);
    nb = st ? size_bytes(instr[14:12]) : 4;
    lane = int'(addr % 4);
    be = st ? 4'(((1 << nb) - 1) << lane) : 4'hf;
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % nb) +: 8];
    if (!st) wd = sd;
    return {st, addr & 32'hffff_fffc, be, wd};
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    int wcnt;
    wcnt = 0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (dmem_req) begin
        if (!resp_never && wcnt == resp_delay) begin
          dmem_ready = 1'b1;
          dmem_rdata = resp_rdata;
        end else begin
          dmem_ready = 1'b0;
          dmem_rdata = $urandom;
        end
        wcnt++;
      end else begin
        // Random ready noise outside an access must be ignored.
        wcnt = 0;
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && wb_valid) begin
        if (exp_q.size() == 0) begin
          check("wb_spurious", W'(1), W'(0));
        end else begin
          check("wb_word",
                {wb_instr, wb_result, wb_read_data, wb_pc, wb_lt, wb_ltu, wb_exc},
                exp_q.pop_front());
        end
      end
      if (dmem_req) begin
        if (!bus_active) check("bus_unexpected_req", W'(1), W'(0));
        else check("bus_fields", W'({dmem_we, dmem_addr, dmem_be, dmem_wdata}), W'(bus_exp));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_junk();
    logic [31:0] r;
    r = $urandom;
    ex_valid      = 1'b0;
    ex_instr      = {r[31:7], r[0] ? 7'h03 : 7'h23};
    ex_result     = $urandom;
    ex_store_data = $urandom;
    ex_pc         = $urandom;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic issue_op(input logic [31:0] instr, addr, sd, pc, input logic lt, ltu,
                          input int delay, input bit never, input logic [31:0] rdata);
    int stalls;
    int exp_stalls;
    int cyc;
    bit done;
    bit bus_op;
    bus_op = is_mem_op(instr) && !is_misaligned(instr, addr);
    exp_stalls = bus_op ? (never ? MAX_WAIT : delay + 1) : 0;
    exp_q.push_back(model_wb(instr, addr, pc, lt, ltu, rdata, never));
    resp_delay = delay;
    resp_never = never;
    resp_rdata = rdata;
    bus_exp    = model_bus(instr, addr, sd);
    bus_active = bus_op;
    ex_valid = 1'b1; ex_instr = instr; ex_result = addr; ex_store_data = sd;
    ex_pc = pc; ex_lt = lt; ex_ltu = ltu;
    stalls = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge clk); #1;
      if (mem_stall) stalls++;
      else done = 1'b1;
      @(posedge clk);
      cyc++;
    end
    if (!done) check("op_completion_bound", W'(0), W'(1));
    bus_active = 1'b0;
    check("stall_cycles", W'(stalls), W'(exp_stalls));
    #1 drive_junk();
    @(negedge clk); #1;
    check("wb_valid_latency", W'(wb_valid), W'(1));
    check("no_stall_idle_gap", W'(mem_stall), W'(0));
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    return {r[31:15], f3, r[11:7], opc};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] ld_f3 [5];
    logic [31:0] ins;
    logic [31:0] addr;
    int kind;
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst = 1'b1;
    ex_valid = 1'b1; ex_instr = 32'h0000_2003; ex_result = 32'h100;
    ex_store_data = '0; ex_pc = '0; ex_lt = 1'b0; ex_ltu = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs_zero",
          W'({mem_stall, dmem_req, wb_valid, wb_exc, dmem_be, dmem_addr, wb_result}), W'(0));
    ex_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a WAIT access.
    resp_never = 1'b1;
    bus_exp    = model_bus(32'h0000_2003, 32'h40, 32'h0);
    bus_active = 1'b1;
    ex_valid = 1'b1; ex_instr = 32'h0000_2003; ex_result = 32'h40;
    repeat (3) @(posedge clk);
    #2;
    check("wait_req_before_rst", W'(dmem_req), W'(1));
    rst = 1'b1;
    bus_active = 1'b0;
    #1;
    check("async_rst_drop", W'({dmem_req, wb_valid, mem_stall}), W'(0));
    ex_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    check("post_rst_idle", W'({dmem_req, mem_stall, wb_valid}), W'(0));
    @(posedge clk); #1;

    // Directed cases.
    issue_op(mk_instr(7'h33, 3'd0), 32'h10, 32'h0, 32'h100, 1'b0, 1'b1, 0, 1'b0, 32'h0);
    issue_op(mk_instr(7'h23, 3'd0), 32'h1003, 32'hA5, 32'h104, 1'b0, 1'b0, 3, 1'b0, 32'h0);
    issue_op(mk_instr(7'h03, 3'd1), 32'h2002, 32'h0, 32'h108, 1'b1, 1'b0, 0, 1'b0, 32'h8001_1234);
    issue_op(mk_instr(7'h03, 3'd2), 32'h3001, 32'h0, 32'h10c, 1'b0, 1'b0, 0, 1'b0, 32'h0);
    issue_op(mk_instr(7'h23, 3'd1), 32'h3003, 32'h1234, 32'h110, 1'b0, 1'b0, 0, 1'b0, 32'h0);
    issue_op(mk_instr(7'h03, 3'd2), 32'h4000, 32'h0, 32'h114, 1'b0, 1'b0, 0, 1'b1, 32'h0);
    issue_op(mk_instr(7'h33, 3'd0), 32'h20, 32'h0, 32'h118, 1'b1, 1'b1, 0, 1'b0, 32'h0);

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      addr = $urandom;
      if (kind == 0) ins = mk_instr($urandom_range(0, 1) ? 7'h33 : 7'h13, 3'($urandom_range(0, 7)));
      else if (kind == 1) ins = mk_instr(7'h03, ld_f3[$urandom_range(0, 4)]);
      else ins = mk_instr(7'h23, 3'($urandom_range(0, 2)));
      issue_op(ins, addr, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 4), ($urandom_range(0, 9) == 0), $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
